// File: rtl/mvm_sparse_feeder.sv
// Buffers {row,col,value} entries, streams them to the sparse MVM accelerator, then captures ROWS results.
// Build option MVM_FEEDER_ZERO_SKIP_EN: zero-valued entries are accepted on load but never stored.
module mvm_sparse_feeder #(
  parameter int DEPTH = 16,
  parameter int ROWS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [1:0] load_row,
  input  logic [1:0] load_col,
  input  logic [7:0] load_value,
  input  logic       go,
  output logic       busy,
  output logic       done,
  input  logic [1:0] res_idx,
  output logic [7:0] res_data,
  input  logic       fetch_ready,
  input  logic       sending_out,
  input  logic [7:0] output_val,
  output logic [1:0] row_val,
  output logic [1:0] column_val,
  output logic [7:0] value,
  output logic       sending_cpu,
  output logic       done_list
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [RW-1:0] LAST_IDX = RW'(ROWS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_END, S_WAIT_OUT, S_FINISH} state_t;

  state_t        state, state_nx;
  logic [11:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_after_wr;
  logic [RW-1:0] cap_idx;
  logic [7:0]    result [ROWS];
  logic          wr_en, store_en, pop, capture;
  logic [11:0]   head;

  assign load_ready = (state == S_IDLE) && (count < DEPTH_C);
  assign wr_en      = load_valid && load_ready;
`ifdef MVM_FEEDER_ZERO_SKIP_EN
  assign store_en   = wr_en && (load_value != 8'd0);
`else
  assign store_en   = wr_en;
`endif
  // A write in the same cycle as go must count toward the run.
  assign count_after_wr = count + CW'(store_en);
  assign pop            = (state == S_SEND) && fetch_ready;
  assign capture        = (state == S_WAIT_OUT) && sending_out;
  assign head           = mem[rd_ptr];

  // Head entry comes straight from flops; the buffer cannot change while sending.
  assign row_val    = sending_cpu ? head[11:10] : 2'd0;
  assign column_val = sending_cpu ? head[9:8]   : 2'd0;
  assign value      = sending_cpu ? head[7:0]   : 8'd0;
  assign res_data   = result[res_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b1;
    done        = 1'b0;
    sending_cpu = 1'b0;
    done_list   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) state_nx = (count_after_wr != '0) ? S_SEND : S_END;
      end
      S_SEND: begin
        sending_cpu = 1'b1;
        if (fetch_ready && count == CW'(1)) state_nx = S_END;
      end
      S_END: begin
        done_list = 1'b1;
        if (fetch_ready) state_nx = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (sending_out && cap_idx == LAST_IDX) state_nx = S_FINISH;
      end
      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      cap_idx <= '0;
      for (int i = 0; i < ROWS; i++) result[i] <= 8'd0;
    end else if (state == S_FINISH) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      cap_idx <= '0;
    end else begin
      if (store_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      count <= count_after_wr - CW'(pop);
      if (capture) begin
        result[cap_idx] <= output_val;
        cap_idx         <= cap_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store_en) mem[wr_ptr] <= {load_row, load_col, load_value};
  end
endmodule

// File: tb/tb_mvm_sparse_feeder.sv
// Directed + randomized bench for mvm_sparse_feeder against a queue/array reference model.
module tb_mvm_sparse_feeder;
  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid, load_ready, go, busy, done;
  logic [1:0] load_row, load_col, res_idx, row_val, column_val;
  logic [7:0] load_value, res_data, output_val, value;
  logic       fetch_ready, sending_out, sending_cpu, done_list;

  always #5 clk = ~clk;

  mvm_sparse_feeder #(.DEPTH(16), .ROWS(4)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_row(load_row), .load_col(load_col), .load_value(load_value),
    .go(go), .busy(busy), .done(done),
    .res_idx(res_idx), .res_data(res_data),
    .fetch_ready(fetch_ready), .sending_out(sending_out), .output_val(output_val),
    .row_val(row_val), .column_val(column_val), .value(value),
    .sending_cpu(sending_cpu), .done_list(done_list)
  );

  int          tests = 0;
  int          fails = 0;
  logic [11:0] sendq[$];
  logic [7:0]  res_model[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit stored(input logic [7:0] v);
`ifdef MVM_FEEDER_ZERO_SKIP_EN
    return v != 8'd0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [11:0] rand_entry();
    logic [7:0] v;
    v = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    return {2'($urandom), 2'($urandom), v};
  endfunction

  task automatic load(input logic [11:0] e, input logic with_go);
    load_valid = 1'b1;
    {load_row, load_col, load_value} = e;
    go = with_go;
    chk("load_ready", load_ready, 1);
    if (stored(e[7:0])) sendq.push_back(e);
    tick();
    load_valid = 1'b0;
    go = 1'b0;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Entered the cycle after go; mode 0 always ready, 1 ready every third cycle, 2 random.
  task automatic run_send(input int mode);
    int idx;
    int cyc;
    int stall;
    bit fr;
    idx = 0;
    cyc = 0;
    chk("busy_run", busy, 1);
    while (!done_list && cyc < 200) begin
      chk("sending_cpu", sending_cpu, 1);
      chk("load_ready_busy", load_ready, 0);
      chk("entry", {row_val, column_val, value}, (idx < sendq.size()) ? sendq[idx] : 12'hfff);
      fr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      fetch_ready = fr;
      if (fr) idx++;
      cyc++;
      tick();
    end
    chk("send_timeout", cyc < 200, 1);
    chk("transfers", idx, sendq.size());
    if (mode == 0) chk("send_cycles", cyc, sendq.size());
    chk("end_sending_cpu", sending_cpu, 0);
    chk("end_fields", {row_val, column_val, value}, 0);
    stall = $urandom_range(0, 2);
    fetch_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk("done_list_hold", done_list, 1);
      tick();
    end
    chk("done_list", done_list, 1);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    chk("done_list_clear", done_list, 0);
    chk("busy_wait", busy, 1);
    sendq.delete();
  endtask

  task automatic capture(input logic [7:0] vals[4], input int gaps[4]);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        sending_out = 1'b0;
        output_val  = 8'($urandom);
        go          = 1'($urandom_range(0, 1));
        tick();
        chk("done_gap", done, 0);
      end
      go          = 1'b0;
      sending_out = 1'b1;
      output_val  = vals[i];
      res_model[i] = vals[i];
      tick();
      sending_out = 1'b0;
      chk("done_pulse", done, i == 3);
      chk("busy_cap", busy, 1);
    end
    tick();
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
    chk("load_ready_idle", load_ready, 1);
    for (int i = 0; i < 4; i++) begin
      res_idx = 2'(i);
      #1;
      chk("result", res_data, res_model[i]);
    end
  endtask

  task automatic capture_rand();
    logic [7:0] vals[4];
    int gaps[4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 8'($urandom);
      gaps[i] = $urandom_range(0, 2);
    end
    capture(vals, gaps);
  endtask

  logic [7:0] dvals[4];
  int         dgaps[4];
  logic [11:0] e;
  int          n;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    load_valid = 0; load_row = 0; load_col = 0; load_value = 0; go = 0;
    res_idx = 0; fetch_ready = 0; sending_out = 0; output_val = 0;
    for (int i = 0; i < 4; i++) res_model[i] = 8'd0;
    #12;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sending_cpu", sending_cpu, 0);
    chk("rst_done_list", done_list, 0);
    chk("rst_fields", {row_val, column_val, value}, 0);
    chk("rst_result", res_data, 0);
    rst = 1'b0;
    tick();

    // Directed three-entry run, always ready, then directed capture with a gap.
    load({2'd0, 2'd1, 8'h05}, 1'b0);
    load({2'd2, 2'd3, 8'h10}, 1'b0);
    load({2'd3, 2'd0, 8'h7F}, 1'b0);
    go_pulse();
    run_send(0);
    dvals = '{8'h11, 8'h22, 8'h33, 8'h44};
    dgaps = '{0, 0, 2, 0};
    capture(dvals, dgaps);

    // Same entries with a 1,0,0 stall pattern.
    load({2'd0, 2'd1, 8'h05}, 1'b0);
    load({2'd2, 2'd3, 8'h10}, 1'b0);
    load({2'd3, 2'd0, 8'h7F}, 1'b0);
    go_pulse();
    run_send(1);
    capture_rand();

    // Fill the buffer; the 17th offer must be dropped.
    for (int i = 0; i < 16; i++) load({2'($urandom), 2'($urandom), 8'($urandom_range(1, 255))}, 1'b0);
    chk("full_load_ready", load_ready, 0);
    load_valid = 1'b1;
    {load_row, load_col, load_value} = 12'hABC;
    tick();
    load_valid = 1'b0;
    chk("full_hold", load_ready, 0);
    go_pulse();
    run_send(0);
    capture_rand();

    // Empty run goes straight to end-of-list.
    go_pulse();
    chk("empty_done_list", done_list, 1);
    chk("empty_sending", sending_cpu, 0);
    run_send(0);
    capture_rand();

    // Zero-valued entry handling.
    load({2'd1, 2'd1, 8'h00}, 1'b0);
    load({2'd1, 2'd2, 8'h09}, 1'b0);
    go_pulse();
    run_send(0);
    capture_rand();

    // Randomized runs, last entry written in the same cycle as go.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        e = rand_entry();
        load(e, i == n - 1);
      end
      if (sendq.size() == 0) chk("rand_empty_done_list", done_list, 1);
      run_send(2);
      capture_rand();
    end

    // Asynchronous reset in the middle of sending.
    for (int i = 0; i < 5; i++) load({2'($urandom), 2'($urandom), 8'($urandom_range(1, 255))}, 1'b0);
    go_pulse();
    fetch_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("pre_rst_entry", {row_val, column_val, value}, sendq[i]);
      tick();
    end
    chk("pre_rst_third", {row_val, column_val, value}, sendq[2]);
    fetch_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sending_cpu", sending_cpu, 0);
    chk("arst_busy", busy, 0);
    chk("arst_load_ready", load_ready, 1);
    chk("arst_fields", {row_val, column_val, value}, 0);
    for (int i = 0; i < 4; i++) begin
      res_idx = 2'(i);
      res_model[i] = 8'd0;
      #1;
      chk("arst_result", res_data, 0);
    end
    rst = 1'b0;
    sendq.delete();
    tick();
    go_pulse();
    chk("arst_count_zero", done_list, 1);
    chk("arst_no_send", sending_cpu, 0);
    run_send(0);
    capture_rand();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
